// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths and bus-slicing helper for the register-file write arbiter.
// Pure declarations; no latency, no backpressure.
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;
    localparam int WCOUNT_W   = 16;

    // Low bit of requester i's field in a packed request bus of w-bit fields.
    function automatic int reg_slice(input int i, input int w);
        return i * w;
    endfunction
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester, register-file and read-path signals of the write arbiter.
// master: requesters plus parent register file; slave: the arbiter.
interface regfile_write_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic                           arb_en;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [REG_ADDR_W*NUM_REQ-1:0]  req_sel;
    logic [DATA_W*NUM_REQ-1:0]      req_data;
    logic                           rf_w_en;
    logic [REG_ADDR_W-1:0]          rf_w_sel;
    logic [DATA_W-1:0]              rf_d;
    logic [1:0]                     grant_id;
    logic                           busy;
    logic [WCOUNT_W-1:0]            write_count;
    logic [REG_ADDR_W-1:0]          a_sel;
    logic [REG_ADDR_W-1:0]          b_sel;
    logic [DATA_W-1:0]              rf_a;
    logic [DATA_W-1:0]              rf_b;
    logic [DATA_W-1:0]              a_out;
    logic [DATA_W-1:0]              b_out;

    modport master (
        output arb_en, req_valid, req_sel, req_data, a_sel, b_sel, rf_a, rf_b,
        input  req_ready, rf_w_en, rf_w_sel, rf_d, grant_id, busy, write_count,
               a_out, b_out
    );

    modport slave (
        input  arb_en, req_valid, req_sel, req_data, a_sel, b_sel, rf_a, rf_b,
        output req_ready, rf_w_en, rf_w_sel, rf_d, grant_id, busy, write_count,
               a_out, b_out
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin grant: search starts one past i_ptr, first requester wins.
// Purely combinational; at most one grant, none when i_en is low.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    input  logic [1:0]   i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [1:0]   o_idx
);
    logic w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = i_ptr;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (i_en && !w_found && i_req[i] && (((int'(i_ptr) + k) % N) == i)) begin
                    o_gnt[i] = 1'b1;
                    o_idx    = 2'(i);
                    w_found  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ requesters, round-robin.
// Latency: handshake -> rf_w_en next edge; optional REGFILE_ARB_BYPASS_EN forwards rf_d to reads.
// Backpressure: req_ready is the grant; low under reset, arb_en=0 or lost arbitration.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DISCARD_R0 = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);
    logic [NUM_REQ-1:0]     w_gnt;
    logic [1:0]             w_idx;
    logic                   w_arb_en;
    logic                   w_hs;
    logic                   w_issue;
    logic [REG_ADDR_W-1:0]  w_sel;
    logic [DATA_W-1:0]      w_data;
    logic                   w_rf_w_en;

    logic                   r_w_en;
    logic [REG_ADDR_W-1:0]  r_w_sel;
    logic [DATA_W-1:0]      r_d;
    logic [1:0]             r_ptr;
    logic [WCOUNT_W-1:0]    r_cnt;

    assign w_arb_en = bus.arb_en && !reset;

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .i_req (bus.req_valid),
        .i_en  (w_arb_en),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    always_comb begin
        w_sel  = '0;
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel  = bus.req_sel[reg_slice(i, REG_ADDR_W) +: REG_ADDR_W];
                w_data = bus.req_data[reg_slice(i, DATA_W) +: DATA_W];
            end
        end
    end

    assign w_hs    = |(w_gnt & bus.req_valid);
    // Writes to r0 complete the handshake but never reach the register file.
    assign w_issue = w_hs && !((DISCARD_R0 != 0) && (w_sel == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_w_en  <= 1'b0;
            r_w_sel <= '0;
            r_d     <= '0;
            r_ptr   <= 2'(NUM_REQ - 1);
            r_cnt   <= '0;
        end else begin
            r_w_en <= w_issue;
            if (w_issue) begin
                r_w_sel <= w_sel;
                r_d     <= w_data;
                r_cnt   <= r_cnt + 1'b1;
            end
            if (w_hs) begin
                r_ptr <= w_idx;
            end
        end
    end

    // Masking with reset stops a write registered last cycle from committing
    // at the same edge that clears it.
    assign w_rf_w_en       = r_w_en && !reset;
    assign bus.req_ready   = w_gnt;
    assign bus.rf_w_en     = w_rf_w_en;
    assign bus.rf_w_sel    = r_w_sel;
    assign bus.rf_d        = r_d;
    assign bus.grant_id    = r_ptr;
    assign bus.busy        = w_rf_w_en;
    assign bus.write_count = r_cnt;

`ifdef REGFILE_ARB_BYPASS_EN
    logic w_fwd_ok;
    assign w_fwd_ok  = w_rf_w_en && !((DISCARD_R0 != 0) && (r_w_sel == '0));
    assign bus.a_out = (w_fwd_ok && bus.a_sel == r_w_sel) ? r_d : bus.rf_a;
    assign bus.b_out = (w_fwd_ok && bus.b_sel == r_w_sel) ? r_d : bus.rf_b;
`else
    assign bus.a_out = bus.rf_a;
    assign bus.b_out = bus.rf_b;
`endif
endmodule
